pipe_ctrl: RTL

//   Pipeline stall controller; the producer of the 6-bit pause vector that the inter-stage

---
 rtl/pipe_ctrl.sv | 59 +++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall controller with multi-cycle EX hold sequencing and stall-cycle counter
module pipe_ctrl #(
  parameter int CNT_W  = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              ex_multi_start,
  input  logic [CNT_W-1:0]  ex_multi_cycles,
  input  logic              flush,
  input  logic              perf_clr,
  output logic [5:0]        pause,
  output logic              multi_busy,
  output logic              multi_done,
  output logic [PERF_W-1:0] stall_cnt
);
  typedef enum logic {IDLE, HOLD} state_t;
  localparam logic [5:0] P_ID = 6'b000111, P_EX = 6'b001111;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic               start_ok, hold, act;
  always_comb begin
    start_ok    = state_q == IDLE && ex_multi_start && ex_multi_cycles != '0;
    hold        = state_q == HOLD || start_ok;
    act         = !rst && !flush;
    multi_busy  = act && hold;
    multi_done  = act && ((state_q == HOLD && rem_q == CNT_W'(1)) ||
                          (start_ok && ex_multi_cycles == CNT_W'(1)));
    pause       = !act ? 6'b0 : (hold || stallreq_ex) ? P_EX : stallreq_id ? P_ID : 6'b0;
    state_d     = state_q;
    rem_d       = rem_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (state_q == HOLD) begin
      rem_d   = rem_q - CNT_W'(1);
      state_d = rem_q == CNT_W'(1) ? IDLE : HOLD;
    end else if (start_ok && ex_multi_cycles != CNT_W'(1)) begin
      rem_d   = ex_multi_cycles - CNT_W'(1);
      state_d = HOLD;
    end
    stall_cnt_d = perf_clr ? '0 : (pause[0] && !(&stall_cnt_q)) ? stall_cnt_q + PERF_W'(1) : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
endmodule
